// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the single-port 256x8 memory, with bulk clear.
// Ports: clk/reset1; req_* (NREQ requesters, packed addr/wdata), rsp_*
// (read return), clr_start/clr_busy, rd_wr1/addr1/wr_data1/rd_data1 (memory).
module mem_arbiter #(
  parameter int NREQ = 4,
  parameter int AW = 8,
  parameter int DW = 8,
  parameter logic [DW-1:0] CLR_VAL = 8'hFF,
  parameter int IW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset1,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_rd_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output logic [DW-1:0]      rsp_data,
  input  logic               clr_start,
  output logic               clr_busy,
  output logic               rd_wr1,
  output logic [AW-1:0]      addr1,
  output logic [DW-1:0]      wr_data1,
  input  logic [DW-1:0]      rd_data1
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] ptr;
  logic [AW-1:0] cnt;
  logic          found;
  logic [IW-1:0] win;
  logic          go;
  logic          v1;
  logic          v2;
  logic [IW-1:0] id1;
  logic [IW-1:0] id2;

  logic [AW-1:0] addr_a [NREQ];
  logic [DW-1:0] wdata_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*AW +: AW];
    assign wdata_a[i] = req_wdata[i*DW +: DW];
  end

  // Scan from ptr upward; descending loop so the nearest valid wins.
  always_comb begin : arb_search
    logic [IW-1:0] idx;
    idx   = '0;
    found = 1'b0;
    win   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // reset1 gates the grant so ready drops without waiting for an edge.
  assign go = found && (state == IDLE) && !clr_start && !reset1;

  always_comb begin
    req_ready = '0;
    if (go) req_ready[win] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (clr_start) state_nx = CLEAR;
      CLEAR:   if (cnt == '1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset1) begin
    if (reset1) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      rd_wr1   <= 1'b1;
      addr1    <= '0;
      wr_data1 <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      id1      <= '0;
      id2      <= '0;
    end else begin
      state <= state_nx;
      v1    <= go && req_rd_wr[win];
      id1   <= win;
      v2    <= v1;
      id2   <= id1;
      if (state == CLEAR) begin
        rd_wr1   <= 1'b0;
        addr1    <= cnt;
        wr_data1 <= CLR_VAL;
        cnt      <= cnt + 1'b1;
      end else if (go) begin
        rd_wr1   <= req_rd_wr[win];
        addr1    <= addr_a[win];
        wr_data1 <= wdata_a[win];
        ptr      <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
      end else begin
        // Idle cycles park the port on a read so nothing gets written.
        rd_wr1 <= 1'b1;
        if (clr_start) cnt <= '0;
      end
    end
  end

  assign rsp_valid = v2;
  assign rsp_id    = id2;
  assign rsp_data  = rd_data1;
  assign clr_busy  = (state == CLEAR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, round-robin model, response scoreboard.
// Ports: none (top-level bench).
module tb_mem_arbiter;
  localparam int NREQ = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam logic [7:0] CLR = 8'hFF;

  logic              clk = 1'b0;
  logic              reset1 = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_rd_wr = '1;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              clr_start = 1'b0;
  logic              clr_busy;
  logic              rd_wr1;
  logic [AW-1:0]     addr1;
  logic [DW-1:0]     wr_data1;
  logic [DW-1:0]     rd_data1;

  mem_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .CLR_VAL(CLR)
  ) dut (
    .clk(clk), .reset1(reset1),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd_wr(req_rd_wr), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .rd_wr1(rd_wr1), .addr1(addr1),
    .wr_data1(wr_data1), .rd_data1(rd_data1)
  );

  always #5 clk = ~clk;

  logic       mem_clr = 1'b1;
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (!rd_wr1) mem[addr1] <= wr_data1;
      rd_data1 <= mem[addr1];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         due;
  } rsp_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp;
  } vec_t;

  rsp_t       q[$];
  logic [7:0] ref_mem [256];
  logic       m_clr = 1'b0;
  logic [7:0] m_cnt = '0;
  int         m_ptr = 0;
  int         m_last = -1;
  int         vec = 0;
  int         errs = 0;
  int         wr_seen = 0;
  int         busy_cnt = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic chk_rst(string t);
    chk({t, ".rd_wr1"}, 32'(rd_wr1), 32'd1);
    chk({t, ".addr1"}, 32'(addr1), 32'd0);
    chk({t, ".wr_data1"}, 32'(wr_data1), 32'd0);
    chk({t, ".req_ready"}, 32'(req_ready), 32'd0);
    chk({t, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({t, ".rsp_id"}, 32'(rsp_id), 32'd0);
    chk({t, ".clr_busy"}, 32'(clr_busy), 32'd0);
  endtask

  task automatic model_reset();
    m_clr = 1'b0;
    m_cnt = '0;
    m_ptr = 0;
    q.delete();
  endtask

  // One clock: check at the falling edge, update the model, step past
  // the rising edge.
  task automatic tick(input bit use_tab = 1'b0,
                      input logic [3:0] tab = 4'h0);
    logic [NREQ-1:0] exp_rdy;
    int   w;
    int   idx;
    rsp_t e;
    @(negedge clk);
    if (!rd_wr1) wr_seen++;
    if (clr_busy) busy_cnt++;
    if (rsp_valid) begin
      if (q.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL rsp_unexp: rsp_valid=1 id=%0d, want no response",
                 rsp_id);
      end else begin
        e = q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_lat", 32'(cyc), 32'(e.due));
      end
    end
    w = -1;
    if (!m_clr && !clr_start) begin
      for (int k = 0; k < NREQ && w < 0; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (req_valid[idx]) w = idx;
      end
    end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("grant", 32'(req_ready), 32'(exp_rdy));
    if (use_tab) chk("rr_tab", 32'(req_ready), 32'(tab));
    chk("clr_busy", 32'(clr_busy), 32'(m_clr));
    if (w >= 0) begin
      if (req_rd_wr[w])
        q.push_back('{w, ref_mem[req_addr[w*AW +: AW]], cyc + 2});
      else
        ref_mem[req_addr[w*AW +: AW]] = req_wdata[w*DW +: DW];
      m_ptr = (w + 1) % NREQ;
    end
    if (m_clr) begin
      ref_mem[m_cnt] = CLR;
      if (m_cnt == 8'hFF) m_clr = 1'b0;
      m_cnt = m_cnt + 8'd1;
    end else if (clr_start) begin
      m_clr = 1'b1;
      m_cnt = '0;
    end
    m_last = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tab [12];
    int   b0;
    int   w0;
    int   bad;
    bit   got;
    tab = '{'{4'hF, 4'h1}, '{4'hF, 4'h2}, '{4'hF, 4'h4}, '{4'hF, 4'h8},
            '{4'hF, 4'h1}, '{4'hF, 4'h2}, '{4'hF, 4'h4}, '{4'hF, 4'h8},
            '{4'hD, 4'h1}, '{4'hD, 4'h4}, '{4'hD, 4'h8}, '{4'hD, 4'h1}};
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    req_valid = 4'hF;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_rst("rst");
    end
    req_valid = '0;
    req_rd_wr = '1;
    req_addr  = {8'h33, 8'h32, 8'h31, 8'h30};
    mem_clr   = 1'b0;
    reset1    = 1'b0;

    for (int i = 0; i < 12; i++) begin
      req_valid = tab[i].valid;
      tick(1'b1, tab[i].exp);
    end
    req_valid = '0;
    repeat (3) tick();

    w0 = wr_seen;
    req_valid = 4'h1;
    req_rd_wr[0] = 1'b0;
    req_addr[7:0] = 8'h10;
    req_wdata[7:0] = 8'hA5;
    tick();
    req_rd_wr[0] = 1'b1;
    tick();
    req_valid = '0;
    repeat (3) tick();
    chk("wr_pulse", 32'(wr_seen - w0), 32'd1);

    req_valid = 4'h6;
    req_rd_wr[1] = 1'b0;
    req_addr[15:8] = 8'h20;
    req_wdata[15:8] = 8'h3C;
    req_rd_wr[2] = 1'b1;
    req_addr[23:16] = 8'h20;
    tick();
    req_valid = 4'h4;
    tick();
    req_valid = '0;
    req_rd_wr[1] = 1'b1;
    repeat (3) tick();

    b0 = busy_cnt;
    req_valid = 4'h1;
    req_addr[7:0] = 8'h7F;
    clr_start = 1'b1;
    tick();
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      clr_start = (i == 100);
      tick();
      if (m_last == 0) got = 1'b1;
    end
    clr_start = 1'b0;
    req_valid = '0;
    chk("clr_timeout", 32'(got), 32'd1);
    repeat (3) tick();
    chk("clr_cycles", 32'(busy_cnt - b0), 32'd256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== CLR) bad++;
    chk("mem_fill", 32'(bad), 32'd0);

    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 100 && m_cnt != 8'h40; i++) tick();
    #2 reset1 = 1'b1;
    model_reset();
    #1 chk_rst("arst_clr");
    @(posedge clk);
    #1 reset1 = 1'b0;
    tick();

    req_valid = 4'h1;
    req_addr[7:0] = 8'h55;
    tick();
    req_valid = '0;
    #2 reset1 = 1'b1;
    model_reset();
    #1 chk_rst("arst_rd");
    @(posedge clk);
    #1 reset1 = 1'b0;
    repeat (4) tick();

    req_valid = 4'hF;
    req_addr = {8'h33, 8'h32, 8'h31, 8'h30};
    tick(1'b1, 4'h1);
    tick(1'b1, 4'h2);
    req_valid = '0;
    repeat (4) tick();
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
